// File: rtl/alu_shift_pkg.sv
// Shared types and ALU control encodings for the CB-prefix rotate/shift sequencer.
// Optional feature macro: ALU_SHIFT_SEQ_SWAP_EN (see alu_shift_seq).
package alu_shift_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned SEL_W  = 3;
  localparam int unsigned LD_W   = 2;

  typedef enum logic [SEL_W-1:0] {
    SEL_RLC  = 3'd0,
    SEL_RRC  = 3'd1,
    SEL_RL   = 3'd2,
    SEL_RR   = 3'd3,
    SEL_SLA  = 3'd4,
    SEL_SRA  = 3'd5,
    SEL_SWAP = 3'd6,
    SEL_SRL  = 3'd7
  } shift_sel_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  // ALU control line encodings
  localparam logic            L_SH   = 1'b0;
  localparam logic            R_SH   = 1'b1;
  localparam logic            SH_OE  = 1'b1;
  localparam logic            RES_OE = 1'b0;
  localparam logic [LD_W-1:0] BUS_LD = 2'b11;
  localparam logic [LD_W-1:0] NO_LD  = 2'b00;

  typedef struct packed {
    logic [DATA_W-1:0] op;
    logic              si;
    logic              sh;
    logic              oe;
    logic [LD_W-1:0]   la;
    logic [LD_W-1:0]   lb;
    logic              r;
    logic              s;
    logic              v;
    logic              ne;
    logic              ci;
    logic              l;
    logic              h;
  } alu_ctl_t;

  // Drive that leaves the ALU untouched (no loads, result output selected)
  localparam alu_ctl_t ALU_CTL_INERT = '{
    op: 8'h00, si: 1'b0, sh: R_SH, oe: RES_OE, la: NO_LD, lb: NO_LD,
    r: 1'b1, s: 1'b1, v: 1'b1, ne: 1'b0, ci: 1'b0, l: 1'b0, h: 1'b0
  };

  function automatic logic [DATA_W-1:0] swap_nibbles(input logic [DATA_W-1:0] b);
    return {b[3:0], b[7:4]};
  endfunction

endpackage

// File: rtl/shift_in_sel.sv
// Shift-in bit and direction selection for each rotate/shift op.
module shift_in_sel
  import alu_shift_pkg::*;
(
  input  logic [SEL_W-1:0]  sel,
  input  logic [DATA_W-1:0] operand,
  input  logic              carry_in,
  output logic              si_c,
  output logic              sh_c
);

  // Only the end bits of the byte can be rotated back in
  logic unused_mid_bits;
  assign unused_mid_bits = ^operand[DATA_W-2:1];

  // Per-op shift-in source and direction; SWAP never reaches the shifter
  always_comb begin
    si_c = 1'b0;
    sh_c = R_SH;
    case (shift_sel_t'(sel))
      SEL_RLC: begin si_c = operand[DATA_W-1]; sh_c = L_SH; end
      SEL_RRC: begin si_c = operand[0];        sh_c = R_SH; end
      SEL_RL:  begin si_c = carry_in;          sh_c = L_SH; end
      SEL_RR:  begin si_c = carry_in;          sh_c = R_SH; end
      SEL_SLA: begin si_c = 1'b0;              sh_c = L_SH; end
      SEL_SRA: begin si_c = operand[DATA_W-1]; sh_c = R_SH; end
      SEL_SRL: begin si_c = 1'b0;              sh_c = R_SH; end
      default: begin si_c = 1'b0;              sh_c = R_SH; end
    endcase
  end

endmodule

// File: rtl/alu_shift_seq.sv
// Micro-sequencer driving the ALU through a two-cycle LO/HI pass for
// CB-prefix rotate/shift ops, returning the byte result with Z/C flags.
// Macro ALU_SHIFT_SEQ_SWAP_EN: SWAP computed locally, bypassing the ALU;
// when undefined SWAP completes with result and flags left unchanged.
module alu_shift_seq
  import alu_shift_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [SEL_W-1:0]  sel,
  input  logic [DATA_W-1:0] operand,
  input  logic              carry_in,
  output logic              busy,
  output logic [DATA_W-1:0] alu_op,
  output logic              alu_si,
  output logic              alu_sh,
  output logic              alu_oe,
  output logic [LD_W-1:0]   alu_la,
  output logic [LD_W-1:0]   alu_lb,
  output logic              alu_r,
  output logic              alu_s,
  output logic              alu_v,
  output logic              alu_ne,
  output logic              alu_ci,
  output logic              alu_l,
  output logic              alu_h,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  input  logic              alu_shift_dbl,
  output logic              done,
  output logic [DATA_W-1:0] res,
  output logic              flag_z,
  output logic              flag_c
);

  state_t            state_q, state_d;
  alu_ctl_t          ctl_q, ctl_d;
  logic              busy_d, done_d;
  logic [DATA_W-1:0] res_d;
  logic              flag_z_d, flag_c_d;
  logic              c_cap_q, c_cap_d;
  logic              si_c, sh_c;

  shift_in_sel u_shift_in_sel (
    .sel      (sel),
    .operand  (operand),
    .carry_in (carry_in),
    .si_c     (si_c),
    .sh_c     (sh_c)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus the ALU drive and result values for the state being entered
  always_comb begin
    state_d  = state_q;
    ctl_d    = ALU_CTL_INERT;
    res_d    = res;
    flag_z_d = flag_z;
    flag_c_d = flag_c;
    c_cap_d  = c_cap_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (shift_sel_t'(sel) == SEL_SWAP) begin
            state_d = DONE;
`ifdef ALU_SHIFT_SEQ_SWAP_EN
            res_d    = swap_nibbles(operand);
            flag_z_d = (swap_nibbles(operand) == DATA_W'(0));
            flag_c_d = 1'b0;
`endif
          end else begin
            state_d  = LO;
            ctl_d.op = operand;
            ctl_d.si = si_c;
            ctl_d.sh = sh_c;
            ctl_d.oe = SH_OE;
            ctl_d.la = BUS_LD;
            ctl_d.lb = BUS_LD;
            ctl_d.l  = 1'b1;
          end
        end
      end
      LO: begin
        state_d = HI;
        c_cap_d = alu_shift_dbl;
        ctl_d.h = 1'b1;
      end
      HI: begin
        state_d  = DONE;
        res_d    = alu_result;
        flag_z_d = alu_zero;
        flag_c_d = c_cap_q;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // Registered outputs and captured flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctl_q   <= ALU_CTL_INERT;
      busy    <= 1'b0;
      done    <= 1'b0;
      res     <= '0;
      flag_z  <= 1'b0;
      flag_c  <= 1'b0;
      c_cap_q <= 1'b0;
    end else begin
      ctl_q   <= ctl_d;
      busy    <= busy_d;
      done    <= done_d;
      res     <= res_d;
      flag_z  <= flag_z_d;
      flag_c  <= flag_c_d;
      c_cap_q <= c_cap_d;
    end
  end

  assign alu_op = ctl_q.op;
  assign alu_si = ctl_q.si;
  assign alu_sh = ctl_q.sh;
  assign alu_oe = ctl_q.oe;
  assign alu_la = ctl_q.la;
  assign alu_lb = ctl_q.lb;
  assign alu_r  = ctl_q.r;
  assign alu_s  = ctl_q.s;
  assign alu_v  = ctl_q.v;
  assign alu_ne = ctl_q.ne;
  assign alu_ci = ctl_q.ci;
  assign alu_l  = ctl_q.l;
  assign alu_h  = ctl_q.h;

endmodule

// File: tb/tb_alu_shift_seq.sv
// Directed bench for alu_shift_seq with a behavioural shifter standing in for the ALU.
module tb_alu_shift_seq;
  import alu_shift_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] sel = 3'd0;
  logic [7:0] operand = 8'h00;
  logic       carry_in = 1'b0;
  logic       busy, done, flag_z, flag_c;
  logic [7:0] alu_op, res;
  logic       alu_si, alu_sh, alu_oe;
  logic [1:0] alu_la, alu_lb;
  logic       alu_r, alu_s, alu_v, alu_ne, alu_ci, alu_l, alu_h;
  logic [7:0] alu_result;
  logic       alu_zero, alu_shift_dbl;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  alu_shift_seq dut (
    .clk(clk), .reset_n(reset_n), .start(start), .sel(sel), .operand(operand),
    .carry_in(carry_in), .busy(busy), .alu_op(alu_op), .alu_si(alu_si),
    .alu_sh(alu_sh), .alu_oe(alu_oe), .alu_la(alu_la), .alu_lb(alu_lb),
    .alu_r(alu_r), .alu_s(alu_s), .alu_v(alu_v), .alu_ne(alu_ne), .alu_ci(alu_ci),
    .alu_l(alu_l), .alu_h(alu_h), .alu_result(alu_result), .alu_zero(alu_zero),
    .alu_shift_dbl(alu_shift_dbl), .done(done), .res(res), .flag_z(flag_z),
    .flag_c(flag_c)
  );

  // Behavioural shifter: loads the shifted byte on BUS_LD, presents it on RES_OE
  logic [7:0] alu_reg = 8'h00;
  always_ff @(posedge clk) begin
    if (alu_la == BUS_LD)
      alu_reg <= (alu_sh == L_SH) ? {alu_op[6:0], alu_si} : {alu_si, alu_op[7:1]};
  end
  assign alu_shift_dbl = (alu_sh == L_SH) ? alu_op[7] : alu_op[0];
  assign alu_result    = (alu_oe == RES_OE) ? alu_reg : 8'h00;
  assign alu_zero      = (alu_result == 8'h00);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic check_inert(input string tag);
    check({tag, "_la"}, 32'(alu_la), 32'(NO_LD));
    check({tag, "_oe"}, 32'(alu_oe), 32'(RES_OE));
    check({tag, "_sh"}, 32'(alu_sh), 32'(R_SH));
    check({tag, "_op"}, 32'(alu_op), 32'h00);
    check({tag, "_lh"}, {30'd0, alu_l, alu_h}, 32'd0);
    check({tag, "_rsv"}, {29'd0, alu_r, alu_s, alu_v}, 32'h7);
  endtask

  // Issue one op; hold_start keeps start asserted through the transaction
  task automatic run_op(input string tag, input logic [2:0] s, input logic [7:0] op,
                        input logic ci, input logic exp_si, input logic exp_sh,
                        input int exp_lat, input logic [7:0] er, input logic ez,
                        input logic ec, input bit hold_start);
    int lat;
    @(negedge clk);
    start = 1'b1; sel = s; operand = op; carry_in = ci;
    @(posedge clk); #1;
    if (hold_start) begin
      sel = SEL_SLA; operand = 8'h02; carry_in = ~ci;
    end else begin
      start = 1'b0;
    end
    check({tag, "_busy"}, 32'(busy), 32'd1);
    if (exp_lat == 3) begin
      check({tag, "_lo_op"}, 32'(alu_op), 32'(op));
      check({tag, "_lo_si"}, 32'(alu_si), 32'(exp_si));
      check({tag, "_lo_sh"}, 32'(alu_sh), 32'(exp_sh));
      check({tag, "_lo_oe"}, 32'(alu_oe), 32'(SH_OE));
      check({tag, "_lo_la"}, {alu_la, alu_lb}, {BUS_LD, BUS_LD});
      check({tag, "_lo_lh"}, {alu_l, alu_h}, 2'b10);
    end else begin
      check_inert({tag, "_byp"});
    end
    lat = 1;
    while (!done && lat < 10) begin
      @(posedge clk); #1;
      lat++;
      if (!done && exp_lat == 3 && lat == 2)
        check({tag, "_hi_lh"}, {alu_l, alu_h, alu_oe, alu_la}, {2'b01, RES_OE, NO_LD});
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_res"}, 32'(res), 32'(er));
    check({tag, "_z"}, 32'(flag_z), 32'(ez));
    check({tag, "_c"}, 32'(flag_c), 32'(ec));
    check({tag, "_dbusy"}, 32'(busy), 32'd1);
    check_inert({tag, "_done"});
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_idle_done"}, 32'(done), 32'd0);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int ndone;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_res", 32'(res), 32'h00);
    check("rst_flags", {flag_z, flag_c}, 2'b00);
    check_inert("rst");
    @(negedge clk); reset_n = 1'b1;

    run_op("rrc01", SEL_RRC, 8'h01, 1'b0, 1'b1, R_SH, 3, 8'h80, 1'b0, 1'b1, 1'b0);
    run_op("rl80",  SEL_RL,  8'h80, 1'b0, 1'b0, L_SH, 3, 8'h00, 1'b1, 1'b1, 1'b0);
    run_op("rlc80", SEL_RLC, 8'h80, 1'b0, 1'b1, L_SH, 3, 8'h01, 1'b0, 1'b1, 1'b0);
    run_op("rr01",  SEL_RR,  8'h01, 1'b1, 1'b1, R_SH, 3, 8'h80, 1'b0, 1'b1, 1'b0);
    run_op("sra81", SEL_SRA, 8'h81, 1'b0, 1'b1, R_SH, 3, 8'hC0, 1'b0, 1'b1, 1'b0);
    run_op("sla40", SEL_SLA, 8'h40, 1'b1, 1'b0, L_SH, 3, 8'h80, 1'b0, 1'b0, 1'b0);

    // start held high through LO, HI and DONE must not queue a second op
    run_op("srl81", SEL_SRL, 8'h81, 1'b0, 1'b0, R_SH, 3, 8'h40, 1'b0, 1'b1, 1'b1);
    ndone = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("ign_ndone", 32'(ndone), 32'd0);
    check("ign_busy", 32'(busy), 32'd0);
    check("ign_res", 32'(res), 32'h40);

    // Reset asserted mid-HI clears everything at once
    @(negedge clk);
    start = 1'b1; sel = SEL_RRC; operand = 8'h01; carry_in = 1'b0;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    check("hi_busy", 32'(busy), 32'd1);
    check("hi_h", 32'(alu_h), 32'd1);
    reset_n = 1'b0;
    #1;
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_done", 32'(done), 32'd0);
    check("mrst_res", 32'(res), 32'h00);
    check("mrst_flags", {flag_z, flag_c}, 2'b00);
    check_inert("mrst");
    @(negedge clk); reset_n = 1'b1;
    run_op("post_sla", SEL_SLA, 8'h40, 1'b0, 1'b0, L_SH, 3, 8'h80, 1'b0, 1'b0, 1'b0);

    // SWAP after a zero/carry result so a missing update is visible
    run_op("pre_swap", SEL_RL, 8'h80, 1'b0, 1'b0, L_SH, 3, 8'h00, 1'b1, 1'b1, 1'b0);
`ifdef ALU_SHIFT_SEQ_SWAP_EN
    run_op("swapF0", SEL_SWAP, 8'hF0, 1'b1, 1'b0, R_SH, 1, 8'h0F, 1'b0, 1'b0, 1'b0);
`else
    run_op("swapF0", SEL_SWAP, 8'hF0, 1'b1, 1'b0, R_SH, 1, 8'h00, 1'b1, 1'b1, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
